mem_stage_master: RTL and testbench

Memory-stage initiator between the EX/MEM pipeline register and the data memory. Takes one load/store request at a time from the pipeline, drives the data memory's doubleword port (combinational read, posedge write), and sequences byte/half/word/double accesses. Sub-doubleword stores run as read-modify-write. The pipeline stalls until the access retires.

---
 rtl/mem_stage_master.sv | 265 ++++++++++++++++++++++++++
 tb/tb_mem_stage_master.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_master.sv
// mem_stage_master
//
// Memory-stage initiator sitting between the EX/MEM pipeline register and the
// data memory. One load/store is accepted at a time. The data memory is driven
// through a doubleword port with a combinational read and a posedge write.
// Byte/half/word/double accesses are sequenced here. Sub-doubleword stores run
// as a read-modify-write of the enclosing doubleword. The pipeline is stalled
// until the access retires.
//
// Ports
//   clk             clock, all state changes on the rising edge
//   reset           synchronous, active-high reset
//   req_valid       access request from EX/MEM (held stable while stall=1)
//   req_write       1 = store, 0 = load
//   req_size        00 byte, 01 half, 10 word, 11 double
//   req_unsigned    loads only: 1 = zero-extend, 0 = sign-extend
//   req_addr        byte address
//   req_wdata       store data, right-aligned
//   stall           holds the pipeline while the access is in progress
//   load_data       extended load result, valid when load_valid=1
//   load_valid      one-cycle pulse in DONE for a successful load
//   misaligned_err  one-cycle pulse in DONE for a misaligned/out-of-range request
//   mem_addr        doubleword-aligned memory address
//   write_data      doubleword written to memory
//   mem_read        memory read enable
//   mem_write       memory write enable (8 bytes written at the clock edge)
//   Read_data       combinational memory read data
module mem_stage_master #(
  parameter int unsigned MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        stall,
  output logic [63:0] load_data,
  output logic        load_valid,
  output logic        misaligned_err,
  output logic [63:0] mem_addr,
  output logic [63:0] write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [63:0] Read_data
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    RMW_READ,
    WRITE,
    DONE
  } state_t;

  state_t      state_q, state_d;

  // Captured request
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic        write_q;
  logic        err_q;

  logic [63:0] merge_q;
  logic [63:0] load_data_q;

  // Request checks, evaluated on the raw request at acceptance
  logic        req_misaligned;
  logic        req_out_of_range;
  logic        req_err;

  // Datapath helpers derived from the captured request
  logic [63:0] base_q;
  logic [2:0]  off_q;
  logic [5:0]  bit_shift;
  logic [63:0] rd_shifted;
  logic [63:0] load_ext;
  logic [7:0]  byte_en;
  logic [63:0] bit_mask;
  logic [63:0] merged;

  // ---------------------------------------------------------------------------
  // Acceptance checks
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path through
    // the block leaves it unassigned; an unassigned path infers a latch.
    req_misaligned = 1'b0;
    case (req_size)
      2'b00: req_misaligned = 1'b0;
      2'b01: req_misaligned = req_addr[0];
      2'b10: req_misaligned = |req_addr[1:0];
      2'b11: req_misaligned = |req_addr[2:0];
      default: req_misaligned = 1'b0;
    endcase
  end

  // Base is at most 2^64-8, so base+7 cannot wrap.
  assign req_out_of_range = ({req_addr[63:3], 3'b000} + 64'd7) >= 64'(MEM_BYTES);
  assign req_err          = req_misaligned | req_out_of_range;

  // ---------------------------------------------------------------------------
  // Load extraction: move the addressed bytes down to bit 0, then extend
  // ---------------------------------------------------------------------------
  assign base_q     = {addr_q[63:3], 3'b000};
  assign off_q      = addr_q[2:0];
  assign bit_shift  = {off_q, 3'b000};
  assign rd_shifted = Read_data >> bit_shift;

  always_comb begin
    load_ext = '0;
    case (size_q)
      2'b00: load_ext = {{56{rd_shifted[7]  & ~unsigned_q}}, rd_shifted[7:0]};
      2'b01: load_ext = {{48{rd_shifted[15] & ~unsigned_q}}, rd_shifted[15:0]};
      2'b10: load_ext = {{32{rd_shifted[31] & ~unsigned_q}}, rd_shifted[31:0]};
      2'b11: load_ext = rd_shifted;
      default: load_ext = rd_shifted;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Store merge: replace bytes [off, off+2^size) of the read doubleword with
  // the low bytes of the store data. Alignment was checked at acceptance, so
  // the lane never crosses the doubleword.
  // ---------------------------------------------------------------------------
  always_comb begin
    byte_en = 8'h00;
    case (size_q)
      2'b00: byte_en = 8'h01 << off_q;
      2'b01: byte_en = 8'h03 << off_q;
      2'b10: byte_en = 8'h0F << off_q;
      2'b11: byte_en = 8'hFF;
      default: byte_en = 8'h00;
    endcase
  end

  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < 8; i++) begin
      bit_mask[8*i +: 8] = {8{byte_en[i]}};
    end
  end

  assign merged = (Read_data & ~bit_mask) | ((wdata_q << bit_shift) & bit_mask);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and output decode. Memory-port outputs depend only on the
  // registered state and captured request, never on req_*.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    stall          = 1'b0;
    load_valid     = 1'b0;
    misaligned_err = 1'b0;
    mem_addr       = '0;
    write_data     = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;

    case (state_q)
      IDLE: begin
        stall = req_valid;
        if (req_valid) begin
          if (req_err) begin
            state_d = DONE;
          end else if (!req_write) begin
            state_d = READ;
          end else if (req_size == 2'b11) begin
            state_d = WRITE;
          end else begin
            state_d = RMW_READ;
          end
        end
      end
      READ: begin
        stall    = 1'b1;
        mem_read = 1'b1;
        mem_addr = base_q;
        state_d  = DONE;
      end
      RMW_READ: begin
        stall    = 1'b1;
        mem_read = 1'b1;
        mem_addr = base_q;
        state_d  = WRITE;
      end
      WRITE: begin
        stall      = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = base_q;
        write_data = merge_q;
        state_d    = DONE;
      end
      DONE: begin
        // The request still present on req_* is the one retiring; it is not
        // sampled again here.
        load_valid     = ~write_q & ~err_q;
        misaligned_err = err_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Captured request
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the request registers are deliberately left without reset; they
    // are always written at acceptance before anything reads them.
    if (state_q == IDLE && req_valid) begin
      addr_q     <= req_addr;
      wdata_q    <= req_wdata;
      size_q     <= req_size;
      unsigned_q <= req_unsigned;
      write_q    <= req_write;
      err_q      <= req_err;
    end
  end

  // ---------------------------------------------------------------------------
  // Load result and store merge buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      load_data_q <= '0;
      merge_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            // Cleared at acceptance so an error retires with load_data = 0.
            load_data_q <= '0;
            if (req_write && req_size == 2'b11) begin
              merge_q <= req_wdata;
            end
          end
        end
        READ:     load_data_q <= load_ext;
        RMW_READ: merge_q     <= merged;
        default: ;
      endcase
    end
  end

  assign load_data = load_data_q;

endmodule

// File: tb/tb_mem_stage_master.sv
// Testbench for mem_stage_master: a doubleword data memory model with
// combinational read and posedge write, a request driver, and a scoreboard of
// expected per-request outcomes checked when each request retires.
module tb_mem_stage_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        stall;
  logic [63:0] load_data;
  logic        load_valid;
  logic        misaligned_err;
  logic [63:0] mem_addr;
  logic [63:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] Read_data;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mem_stage_master #(.MEM_BYTES(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .stall          (stall),
    .load_data      (load_data),
    .load_valid     (load_valid),
    .misaligned_err (misaligned_err),
    .mem_addr       (mem_addr),
    .write_data     (write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .Read_data      (Read_data)
  );

  // ---------------------------------------------------------------------------
  // Data memory model: 8 doublewords, no reset
  // ---------------------------------------------------------------------------
  logic [63:0] mem [8];
  logic        load_mem = 1'b0;
  logic [2:0]  load_idx;
  logic [63:0] load_val;
  int          write_count = 0;

  always @(posedge clk) begin
    if (load_mem) begin
      mem[load_idx] <= load_val;
    end else if (mem_write) begin
      mem[mem_addr[5:3]] <= write_data;
      write_count        <= write_count + 1;
    end
  end

  assign Read_data = mem[mem_addr[5:3]];

  task automatic preload(input logic [2:0] idx, input logic [63:0] val);
    load_idx = idx;
    load_val = val;
    load_mem = 1'b1;
    @(posedge clk);
    #1 load_mem = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Request / outcome records
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic        w;
    logic [1:0]  sz;
    logic        uns;
    logic [63:0] a;
    logic [63:0] wd;
  } req_t;

  typedef struct packed {
    logic [7:0]  cycles;      // acceptance cycle T to DONE
    logic        stall_ok;    // stall high in every cycle before DONE
    logic        both;        // mem_read and mem_write seen together
    logic        lv;
    logic        err;
    logic [63:0] ld;
    logic [3:0]  n_read;
    logic [63:0] raddr;
    logic [3:0]  n_write;
    logic [63:0] waddr;
    logic [63:0] wdata;
    logic        lv_after;    // load_valid in the cycle after DONE
    logic        err_after;   // misaligned_err in the cycle after DONE
    logic        stall_after; // stall in the cycle after DONE (req dropped)
  } res_t;

  res_t exp_q[$];

  function automatic req_t mk_req(input logic w, input logic [1:0] sz, input logic uns,
                                  input logic [63:0] a, input logic [63:0] wd);
    req_t r;
    r.w = w; r.sz = sz; r.uns = uns; r.a = a; r.wd = wd;
    return r;
  endfunction

  function automatic res_t mk_exp(input int cyc, input logic lv, input logic err,
                                  input logic [63:0] ld, input int nr, input logic [63:0] ra,
                                  input int nw, input logic [63:0] wa, input logic [63:0] wd);
    res_t e;
    e = '0;
    e.cycles   = 8'(cyc);
    e.stall_ok = 1'b1;
    e.lv       = lv;
    e.err      = err;
    e.ld       = ld;
    e.n_read   = 4'(nr);
    e.raddr    = ra;
    e.n_write  = 4'(nw);
    e.waddr    = wa;
    e.wdata    = wd;
    return e;
  endfunction

  // Drive one request, follow it to DONE (bounded) and record what was seen.
  task automatic run_req(input req_t r, output res_t o);
    bit done;
    o = '0;
    o.stall_ok = 1'b1;
    done = 1'b0;
    @(posedge clk);
    #1;
    req_write    = r.w;
    req_size     = r.sz;
    req_unsigned = r.uns;
    req_addr     = r.a;
    req_wdata    = r.wd;
    req_valid    = 1'b1;
    for (int k = 0; k < 12 && !done; k++) begin
      @(negedge clk);
      if (mem_read && mem_write) o.both = 1'b1;
      if (mem_read) begin
        o.n_read = o.n_read + 4'd1;
        o.raddr  = mem_addr;
      end
      if (mem_write) begin
        o.n_write = o.n_write + 4'd1;
        o.waddr   = mem_addr;
        o.wdata   = write_data;
      end
      if (k > 0 && !stall) begin
        done     = 1'b1;
        o.cycles = 8'(k);
        o.lv     = load_valid;
        o.err    = misaligned_err;
        o.ld     = load_data;
      end else if (!stall) begin
        o.stall_ok = 1'b0;
      end
    end
    if (!done) o.cycles = 8'hFF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    o.lv_after    = load_valid;
    o.err_after   = misaligned_err;
    o.stall_after = stall;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({load_data, write_data, mem_addr, load_valid, misaligned_err, mem_read, mem_write, stall} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: got ld=%h wd=%h ma=%h lv=%b err=%b rd=%b wr=%b stall=%b, want all zero",
               load_data, write_data, mem_addr, load_valid, misaligned_err, mem_read, mem_write, stall);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_loads();
    req_t reqs[6];
    res_t exps[6];
    res_t o, e;
    reqs[0] = mk_req(1'b0, 2'b11, 1'b0, 64'd0,  64'd0);
    exps[0] = mk_exp(2, 1'b1, 1'b0, 64'h4, 1, 64'd0, 0, 64'd0, 64'd0);
    reqs[1] = mk_req(1'b0, 2'b00, 1'b0, 64'd9,  64'd0);
    exps[1] = mk_exp(2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'd8, 0, 64'd0, 64'd0);
    reqs[2] = mk_req(1'b0, 2'b01, 1'b1, 64'd8,  64'd0);
    exps[2] = mk_exp(2, 1'b1, 1'b0, 64'hFF10, 1, 64'd8, 0, 64'd0, 64'd0);
    reqs[3] = mk_req(1'b0, 2'b10, 1'b0, 64'd8,  64'd0);
    exps[3] = mk_exp(2, 1'b1, 1'b0, 64'hFFFF_FFFF_8000_FF10, 1, 64'd8, 0, 64'd0, 64'd0);
    reqs[4] = mk_req(1'b0, 2'b00, 1'b1, 64'd11, 64'd0);
    exps[4] = mk_exp(2, 1'b1, 1'b0, 64'h80, 1, 64'd8, 0, 64'd0, 64'd0);
    reqs[5] = mk_req(1'b0, 2'b01, 1'b0, 64'd10, 64'd0);
    exps[5] = mk_exp(2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_8000, 1, 64'd8, 0, 64'd0, 64'd0);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(exps[i]);
      run_req(reqs[i], o);
      e = exp_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL load_%0d addr=%0d: got cyc=%0d ld=%h lv=%b err=%b rd=%0d@%h wr=%0d flags=%b%b%b%b%b, want cyc=%0d ld=%h lv=%b err=%b rd=%0d@%h wr=%0d flags=%b%b%b%b%b",
                 i, reqs[i].a, o.cycles, o.ld, o.lv, o.err, o.n_read, o.raddr, o.n_write,
                 o.stall_ok, o.both, o.lv_after, o.err_after, o.stall_after,
                 e.cycles, e.ld, e.lv, e.err, e.n_read, e.raddr, e.n_write,
                 e.stall_ok, e.both, e.lv_after, e.err_after, e.stall_after);
      end
    end
  endtask

  task automatic test_stores();
    req_t reqs[8];
    res_t exps[8];
    res_t o, e;
    // Byte 0xAB into offset 2 of doubleword 16 (holding 0x3)
    reqs[0] = mk_req(1'b1, 2'b00, 1'b0, 64'd18, 64'hAB);
    exps[0] = mk_exp(3, 1'b0, 1'b0, 64'd0, 1, 64'd16, 1, 64'd16, 64'h0000_0000_00AB_0003);
    reqs[1] = mk_req(1'b0, 2'b11, 1'b0, 64'd16, 64'd0);
    exps[1] = mk_exp(2, 1'b1, 1'b0, 64'h0000_0000_00AB_0003, 1, 64'd16, 0, 64'd0, 64'd0);
    // Full doubleword: straight to WRITE, no read
    reqs[2] = mk_req(1'b1, 2'b11, 1'b0, 64'd24, 64'h1122_3344_5566_7788);
    exps[2] = mk_exp(2, 1'b0, 1'b0, 64'd0, 0, 64'd0, 1, 64'd24, 64'h1122_3344_5566_7788);
    reqs[3] = mk_req(1'b0, 2'b11, 1'b0, 64'd24, 64'd0);
    exps[3] = mk_exp(2, 1'b1, 1'b0, 64'h1122_3344_5566_7788, 1, 64'd24, 0, 64'd0, 64'd0);
    // Half with junk in the upper store-data bits, which must be ignored
    reqs[4] = mk_req(1'b1, 2'b01, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_BEEF);
    exps[4] = mk_exp(3, 1'b0, 1'b0, 64'd0, 1, 64'd16, 1, 64'd16, 64'h0000_BEEF_00AB_0003);
    reqs[5] = mk_req(1'b0, 2'b10, 1'b1, 64'd20, 64'd0);
    exps[5] = mk_exp(2, 1'b1, 1'b0, 64'h0000_BEEF, 1, 64'd16, 0, 64'd0, 64'd0);
    // Upper word of doubleword 24
    reqs[6] = mk_req(1'b1, 2'b10, 1'b0, 64'd28, 64'h89AB_CDEF);
    exps[6] = mk_exp(3, 1'b0, 1'b0, 64'd0, 1, 64'd24, 1, 64'd24, 64'h89AB_CDEF_5566_7788);
    reqs[7] = mk_req(1'b0, 2'b10, 1'b0, 64'd28, 64'd0);
    exps[7] = mk_exp(2, 1'b1, 1'b0, 64'hFFFF_FFFF_89AB_CDEF, 1, 64'd24, 0, 64'd0, 64'd0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(exps[i]);
      run_req(reqs[i], o);
      e = exp_q.pop_front();
      // load_data carries no meaning for a store that retires cleanly
      if (!e.lv && !e.err) o.ld = e.ld;
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL store_seq_%0d addr=%0d: got cyc=%0d ld=%h lv=%b rd=%0d@%h wr=%0d@%h data=%h flags=%b%b%b%b%b, want cyc=%0d ld=%h lv=%b rd=%0d@%h wr=%0d@%h data=%h flags=%b%b%b%b%b",
                 i, reqs[i].a, o.cycles, o.ld, o.lv, o.n_read, o.raddr, o.n_write, o.waddr, o.wdata,
                 o.stall_ok, o.both, o.lv_after, o.err_after, o.stall_after,
                 e.cycles, e.ld, e.lv, e.n_read, e.raddr, e.n_write, e.waddr, e.wdata,
                 e.stall_ok, e.both, e.lv_after, e.err_after, e.stall_after);
      end
    end
  endtask

  task automatic test_errors();
    req_t reqs[7];
    res_t exps[7];
    res_t o, e;
    preload(3'd7, 64'hCAFE_BABE_1234_5678);
    // Last in-range doubleword: base 56 + 7 = 63
    reqs[0] = mk_req(1'b0, 2'b11, 1'b0, 64'd56, 64'd0);
    exps[0] = mk_exp(2, 1'b1, 1'b0, 64'hCAFE_BABE_1234_5678, 1, 64'd56, 0, 64'd0, 64'd0);
    reqs[1] = mk_req(1'b0, 2'b01, 1'b0, 64'd3, 64'd0);
    exps[1] = mk_exp(1, 1'b0, 1'b1, 64'd0, 0, 64'd0, 0, 64'd0, 64'd0);
    reqs[2] = mk_req(1'b1, 2'b10, 1'b0, 64'd6, 64'h1234_5678);
    exps[2] = mk_exp(1, 1'b0, 1'b1, 64'd0, 0, 64'd0, 0, 64'd0, 64'd0);
    reqs[3] = mk_req(1'b0, 2'b10, 1'b1, 64'd60, 64'd0);
    exps[3] = mk_exp(2, 1'b1, 1'b0, 64'hCAFE_BABE, 1, 64'd56, 0, 64'd0, 64'd0);
    reqs[4] = mk_req(1'b0, 2'b11, 1'b0, 64'd64, 64'd0);
    exps[4] = mk_exp(1, 1'b0, 1'b1, 64'd0, 0, 64'd0, 0, 64'd0, 64'd0);
    reqs[5] = mk_req(1'b1, 2'b00, 1'b0, 64'h100, 64'h5A);
    exps[5] = mk_exp(1, 1'b0, 1'b1, 64'd0, 0, 64'd0, 0, 64'd0, 64'd0);
    reqs[6] = mk_req(1'b1, 2'b11, 1'b0, 64'd4, 64'hDEAD_DEAD_DEAD_DEAD);
    exps[6] = mk_exp(1, 1'b0, 1'b1, 64'd0, 0, 64'd0, 0, 64'd0, 64'd0);
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(exps[i]);
      run_req(reqs[i], o);
      e = exp_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL error_seq_%0d addr=%0h: got cyc=%0d ld=%h lv=%b err=%b rd=%0d wr=%0d flags=%b%b%b%b%b, want cyc=%0d ld=%h lv=%b err=%b rd=%0d wr=%0d flags=%b%b%b%b%b",
                 i, reqs[i].a, o.cycles, o.ld, o.lv, o.err, o.n_read, o.n_write,
                 o.stall_ok, o.both, o.lv_after, o.err_after, o.stall_after,
                 e.cycles, e.ld, e.lv, e.err, e.n_read, e.n_write,
                 e.stall_ok, e.both, e.lv_after, e.err_after, e.stall_after);
      end
    end
    tests_run++;
    if (mem[0] !== 64'h4) begin
      tests_failed++;
      $display("FAIL error_no_write: mem[0] got %h, want %h", mem[0], 64'h4);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] saved;
    int          wc0;
    saved = mem[2];
    wc0   = write_count;
    @(posedge clk);
    #1;
    req_write    = 1'b1;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 64'd17;
    req_wdata    = 64'h55;
    req_valid    = 1'b1;
    @(negedge clk);              // acceptance cycle T
    @(negedge clk);              // T+1: RMW_READ
    tests_run++;
    if ({mem_read, mem_write, stall, mem_addr} !== {1'b1, 1'b0, 1'b1, 64'd16}) begin
      tests_failed++;
      $display("FAIL rmw_read_phase: got rd=%b wr=%b stall=%b addr=%h, want rd=1 wr=0 stall=1 addr=%h",
               mem_read, mem_write, stall, mem_addr, 64'd16);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({load_data, write_data, mem_addr, load_valid, misaligned_err, mem_read, mem_write, stall} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: got ld=%h wd=%h ma=%h lv=%b err=%b rd=%b wr=%b stall=%b, want all zero",
               load_data, write_data, mem_addr, load_valid, misaligned_err, mem_read, mem_write, stall);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (write_count != wc0 || mem[2] !== saved) begin
      tests_failed++;
      $display("FAIL reset_mid_memory: got writes=%0d mem16=%h, want writes=%0d mem16=%h",
               write_count - wc0, mem[2], 0, saved);
    end
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    load_idx     = '0;
    load_val     = '0;

    test_reset();
    preload(3'd0, 64'h0000_0000_0000_0004);
    preload(3'd1, 64'h0000_0000_8000_FF10);
    preload(3'd2, 64'h0000_0000_0000_0003);
    for (int i = 3; i < 8; i++) preload(3'(i), 64'd0);

    test_loads();
    test_stores();
    test_errors();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
